// File: rtl/mode_manager_n.sv
// mode_manager_n: tracks function mode, FND display page and per-mode run/stop flags.
// Optional build macro MODE_LOCK_EN: mode changes are discarded while the current mode is running.

module mode_manager_n_swsync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_i,
  output logic flip_o
);
  logic [STAGES-1:0] sync_q;
  logic              edge_q;

  // Edge register always follows the synced level, so a flip that is ignored is also consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], sw_i};
      edge_q <= sync_q[STAGES-1];
    end
  end

  assign flip_o = sync_q[STAGES-1] ^ edge_q;
endmodule

module mode_manager_n #(
  parameter int                     NUM_MODES   = 4,
  parameter int                     NUM_PAGES   = 2,
  parameter logic [NUM_MODES-1:0]   RUN_MASK    = NUM_MODES'(1),
  parameter int                     SYNC_STAGES = 2,
  localparam int                    MODE_W      = $clog2(NUM_MODES),
  localparam int                    PAGE_W      = $clog2(NUM_PAGES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sw_mode,
  input  logic                 sw_page,
  input  logic                 mode_next_pulse,
  input  logic                 mode_prev_pulse,
  input  logic                 page_next_pulse,
  input  logic                 runstop_pulse,
  input  logic                 run_clear_pulse,
  output logic [MODE_W-1:0]    cur_mode,
  output logic [PAGE_W-1:0]    cur_page,
  output logic [NUM_MODES-1:0] run_vec,
  output logic                 cur_running,
  output logic                 mode_changed
);
  localparam int PRIME_MAX = SYNC_STAGES + 1;
  localparam int PRIME_W   = $clog2(PRIME_MAX + 1);

  logic [MODE_W-1:0]    mode_q, mode_d;
  logic [PAGE_W-1:0]    page_q, page_d;
  logic [NUM_MODES-1:0] run_q, run_d;
  logic                 chg_q, chg_d;
  logic [PRIME_W-1:0]   prime_q, prime_d;
  logic [1:0]           flip;
  logic                 primed, lock, adv, ret, padv;

  // Index 0: mode switch, index 1: page switch.
  mode_manager_n_swsync #(.STAGES(SYNC_STAGES)) u_sync [1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_i  ({sw_page, sw_mode}),
    .flip_o(flip)
  );

  assign primed = (prime_q == PRIME_W'(PRIME_MAX));

`ifdef MODE_LOCK_EN
  assign lock = run_q[mode_q];
`else
  assign lock = 1'b0;
`endif

  assign adv  = (mode_next_pulse | (flip[0] & primed)) & ~lock;
  assign ret  = mode_prev_pulse & ~lock;
  assign padv = page_next_pulse | (flip[1] & primed);

  always_comb begin
    mode_d  = mode_q;
    page_d  = page_q;
    run_d   = run_q;
    prime_d = primed ? prime_q : prime_q + 1'b1;

    if (adv && !ret)
      mode_d = (mode_q == MODE_W'(NUM_MODES - 1)) ? '0 : mode_q + 1'b1;
    else if (ret && !adv)
      mode_d = (mode_q == '0) ? MODE_W'(NUM_MODES - 1) : mode_q - 1'b1;

    if (padv)
      page_d = (page_q == PAGE_W'(NUM_PAGES - 1)) ? '0 : page_q + 1'b1;

    // Toggle targets the mode shown this cycle, not the one being switched to.
    if (run_clear_pulse)
      run_d = '0;
    else if (runstop_pulse && RUN_MASK[mode_q])
      run_d[mode_q] = ~run_q[mode_q];
    run_d = run_d & RUN_MASK;

    chg_d = (mode_d != mode_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= '0;
      page_q  <= '0;
      run_q   <= '0;
      chg_q   <= 1'b0;
      prime_q <= '0;
    end else begin
      mode_q  <= mode_d;
      page_q  <= page_d;
      run_q   <= run_d;
      chg_q   <= chg_d;
      prime_q <= prime_d;
    end
  end

  assign cur_mode     = mode_q;
  assign cur_page     = page_q;
  assign run_vec      = run_q;
  assign cur_running  = run_q[mode_q];
  assign mode_changed = chg_q;
endmodule

// File: tb/tb_mode_manager_n.sv
// Scoreboarded random + directed bench for mode_manager_n against an arithmetic reference model.
module tb_mode_manager_n;
  localparam int NM = 4;
  localparam int NP = 3;
  localparam int S  = 2;
  localparam logic [NM-1:0] MASK = 4'b0101;

  logic clk = 1'b0, rst_n = 1'b1;
  logic sw_mode = 1'b0, sw_page = 1'b0;
  logic mnp = 1'b0, mpp = 1'b0, pnp = 1'b0, rsp = 1'b0, rcp = 1'b0;
  logic [1:0]    cur_mode, cur_page;
  logic [NM-1:0] run_vec;
  logic          cur_running, mode_changed;

  always #5 clk = ~clk;

  mode_manager_n #(.NUM_MODES(NM), .NUM_PAGES(NP), .RUN_MASK(MASK), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .sw_mode(sw_mode), .sw_page(sw_page),
    .mode_next_pulse(mnp), .mode_prev_pulse(mpp), .page_next_pulse(pnp),
    .runstop_pulse(rsp), .run_clear_pulse(rcp),
    .cur_mode(cur_mode), .cur_page(cur_page), .run_vec(run_vec),
    .cur_running(cur_running), .mode_changed(mode_changed)
  );

  typedef struct packed {
    logic [1:0]    mode;
    logic [1:0]    page;
    logic [NM-1:0] run;
    logic          running;
    logic          chg;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0;

  // Reference model state: plain integers, flips scheduled by the edge they land on.
  int        m_mode, m_page, cyc;
  bit [NM-1:0] m_run;
  bit        fm[int], fp[int];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  exp_t me;
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("cur_mode", cur_mode, me.mode);
      chk("cur_page", cur_page, me.page);
      chk("run_vec", run_vec, me.run);
      chk("cur_running", cur_running, me.running);
      chk("mode_changed", mode_changed, me.chg);
    end
  end

  task automatic model_reset();
    m_mode = 0; m_page = 0; m_run = '0; cyc = 1;
    fm.delete(); fp.delete();
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, "_mode"}, cur_mode, 0);
    chk({tag, "_page"}, cur_page, 0);
    chk({tag, "_run"}, run_vec, 0);
    chk({tag, "_running"}, cur_running, 0);
    chk({tag, "_chg"}, mode_changed, 0);
  endtask

  // Called just after a falling edge; models the next rising edge.
  task automatic step(bit mn = 0, bit mp = 0, bit pn = 0, bit rs = 0, bit rc = 0,
                      bit tm = 0, bit tp = 0);
    exp_t e;
    bit   flm, flp, lock, adv, ret;
    int   old;
    mnp = mn; mpp = mp; pnp = pn; rsp = rs; rcp = rc;
    if (tm) begin sw_mode = ~sw_mode; fm[cyc + S] = 1'b1; end
    if (tp) begin sw_page = ~sw_page; fp[cyc + S] = 1'b1; end
    flm = fm.exists(cyc) && (cyc >= S + 2);
    flp = fp.exists(cyc) && (cyc >= S + 2);
    fm.delete(cyc); fp.delete(cyc);
`ifdef MODE_LOCK_EN
    lock = m_run[m_mode];
`else
    lock = 1'b0;
`endif
    adv = (mn | flm) & ~lock;
    ret = mp & ~lock;
    old = m_mode;
    if (rc) m_run = '0;
    else if (rs && MASK[m_mode]) m_run[m_mode] = ~m_run[m_mode];
    if (adv && !ret)      m_mode = (m_mode + 1) % NM;
    else if (ret && !adv) m_mode = (m_mode + NM - 1) % NM;
    if (pn | flp) m_page = (m_page + 1) % NP;
    e.mode = 2'(m_mode); e.page = 2'(m_page); e.run = m_run;
    e.running = m_run[m_mode]; e.chg = (m_mode != old);
    q.push_back(e);
    @(negedge clk);
    cyc++;
  endtask

  task automatic rand_steps(int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    step();
  endtask

  initial begin
    // Reset with the mode switch held high: no spurious advance after release.
    #1 rst_n = 1'b0;
    sw_mode = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;
    model_reset();
    repeat (10) step();

    repeat (4) step(.mn(1));          // 1,2,3,0
    step(.mp(1));                     // 0 -> 3
    step(.mn(1), .mp(1));             // no change
    step(.mn(1));                     // 3 -> 0

    step(.tm(1)); step(); step(); step();   // switch flip lands S edges later
    step(.tm(1)); step(); step(.mn(1)); step();   // flip + pulse = one advance

    step(.mp(1)); step(.mp(1));       // back to 0
    step(.rs(1));                     // run 0001
    step(.mn(1), .rs(1));             // run 0000, mode 1
    step(.rs(1));                     // mask 0: ignored
    step(.mp(1));
    step(.rs(1));
    step(.rs(1), .rc(1));             // clear wins

    repeat (3) step(.pn(1));          // page wrap at NUM_PAGES=3
    step(.tp(1)); step(); step(.pn(1)); step();

    step(.rs(1));                     // mode 0 running
    step(.mn(1), .tm(1)); step(); step(); step();
    step(.rs(1));
    step(.mn(1)); step(); step(); step();

    rand_steps(400);

    // Asynchronous reset mid-cycle clears immediately; priming restarts.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 chk_reset_state("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (6) step();
    rand_steps(300);

    @(posedge clk); #3;
    chk("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
